// File: rtl/dense_feeder.sv
// ---------------------------------------------------------------------------
// dense_feeder
//
// Sequencer for the dense (fully connected) classification layer. For every
// output class it streams the N_FEAT feature words from the feature buffer,
// paired with that class's weights, into an external MAC. It then collects
// the accumulated score and keeps the running arg-max. When the last class
// has been scored it reports the winning texture class.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           start one classification (sampled only while idle)
//   o_feat_addr       feature buffer read address (1-cycle read latency)
//   i_feat_data       feature word returned by the buffer (unsigned)
//   o_wgt_addr        weight memory read address (1-cycle read latency)
//   i_wgt_data        weight returned by the memory (signed)
//   o_mac_clr         one-cycle accumulator clear ahead of each class
//   o_mac_valid       o_ni_rd / o_weight carry a beat this cycle
//   o_mac_last        beat is the final element of the class
//   o_ni_rd, o_weight operand pair presented to the MAC
//   i_mac_done        MAC result ready
//   i_mac_dout        MAC result (signed)
//   o_score_valid     one-cycle pulse per captured class score
//   o_score_idx       class index belonging to o_score
//   o_score           captured class score
//   o_busy            high whenever a classification is in progress
//   o_done            one-cycle pulse at the end of a classification
//   o_class           arg-max class, held until the next o_done
// ---------------------------------------------------------------------------
module dense_feeder #(
  parameter int N_FEAT  = 256,
  parameter int N_CLASS = 8,
  parameter int FEAT_W  = 24,
  parameter int WGT_W   = 24,
  parameter int ACC_W   = 56,
  parameter int FA_W    = $clog2(N_FEAT),
  parameter int WA_W    = $clog2(N_FEAT * N_CLASS),
  parameter int CI_W    = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic [FA_W-1:0]         o_feat_addr,
  input  logic [FEAT_W-1:0]       i_feat_data,
  output logic [WA_W-1:0]         o_wgt_addr,
  input  logic signed [WGT_W-1:0] i_wgt_data,
  output logic                    o_mac_clr,
  output logic                    o_mac_valid,
  output logic                    o_mac_last,
  output logic [FEAT_W-1:0]       o_ni_rd,
  output logic signed [WGT_W-1:0] o_weight,
  input  logic                    i_mac_done,
  input  logic signed [ACC_W-1:0] i_mac_dout,
  output logic                    o_score_valid,
  output logic [CI_W-1:0]         o_score_idx,
  output logic signed [ACC_W-1:0] o_score,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CI_W-1:0]         o_class
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [FA_W-1:0] FEAT_LAST = FA_W'(N_FEAT - 1);
  localparam logic [CI_W-1:0] CLS_LAST  = CI_W'(N_CLASS - 1);

  // The first class always seeds the maximum; afterwards only a strictly
  // larger signed score replaces it, so ties keep the lower class index.
  function automatic logic beats_max(input logic signed [ACC_W-1:0] score,
                                     input logic signed [ACC_W-1:0] best,
                                     input logic                    first);
    return first || (score > best);
  endfunction

  state_t                  state_q, state_d;
  logic [FA_W-1:0]         feat_q;
  logic [CI_W-1:0]         cls_q;
  logic [WA_W-1:0]         wa_q;
  logic                    drain_q;
  logic signed [ACC_W-1:0] max_q;
  logic [CI_W-1:0]         max_idx_q;
  logic [CI_W-1:0]         class_q;
  logic signed [ACC_W-1:0] score_q;
  logic [CI_W-1:0]         score_idx_q;
  logic                    score_vld_q;

  logic                    vld_p0, last_p0;
  logic                    vld_p1, last_p1;
  logic [FEAT_W-1:0]       ni_rd_p1;
  logic signed [WGT_W-1:0] weight_p1;

  logic feat_is_last;
  logic cls_is_last;
  logic score_take;

  assign feat_is_last = (feat_q == FEAT_LAST);
  assign cls_is_last  = (cls_q == CLS_LAST);
  assign score_take   = (state_q == S_WAIT) && i_mac_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start) state_d = S_CLR;
      S_CLR:    state_d = S_STREAM;
      S_STREAM: if (feat_is_last) state_d = S_DRAIN;
      // Two cycles let the final address ripple through the memory read
      // and the output register before waiting on the MAC.
      S_DRAIN:  if (drain_q) state_d = S_WAIT;
      S_WAIT:   if (i_mac_done) state_d = S_NEXT;
      S_NEXT:   state_d = cls_is_last ? S_DONE : S_CLR;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencing counters, score capture and arg-max tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      feat_q      <= '0;
      cls_q       <= '0;
      wa_q        <= '0;
      drain_q     <= 1'b0;
      max_q       <= '0;
      max_idx_q   <= '0;
      class_q     <= '0;
      score_q     <= '0;
      score_idx_q <= '0;
      score_vld_q <= 1'b0;
    end else begin
      score_vld_q <= score_take;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cls_q  <= '0;
            feat_q <= '0;
            wa_q   <= '0;
          end
        end
        S_CLR: begin
          feat_q <= '0;
        end
        S_STREAM: begin
          // Weights of consecutive classes are contiguous, so a single
          // running address equals cls*N_FEAT + feat.
          feat_q  <= feat_is_last ? '0 : feat_q + FA_W'(1);
          wa_q    <= wa_q + WA_W'(1);
          drain_q <= 1'b0;
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
        end
        S_WAIT: begin
          if (i_mac_done) begin
            score_q     <= i_mac_dout;
            score_idx_q <= cls_q;
            if (beats_max(i_mac_dout, max_q, cls_q == '0)) begin
              max_q     <= i_mac_dout;
              max_idx_q <= cls_q;
            end
          end
        end
        S_NEXT: begin
          if (cls_is_last) begin
            class_q <= max_idx_q;
          end else begin
            cls_q <= cls_q + CI_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: address cycle recorded; memory data arrives during p0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= (state_q == S_STREAM);
      last_p0 <= (state_q == S_STREAM) && feat_is_last;
    end
  end

  // Stage p1: memory data registered toward the MAC; operands hold
  // their last value between beats.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      ni_rd_p1  <= '0;
      weight_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (vld_p0) begin
        ni_rd_p1  <= i_feat_data;
        weight_p1 <= i_wgt_data;
      end
    end
  end

  assign o_feat_addr   = feat_q;
  assign o_wgt_addr    = wa_q;
  assign o_mac_clr     = (state_q == S_CLR);
  assign o_mac_valid   = vld_p1;
  assign o_mac_last    = last_p1;
  assign o_ni_rd       = ni_rd_p1;
  assign o_weight      = weight_p1;
  assign o_score_valid = score_vld_q;
  assign o_score_idx   = score_idx_q;
  assign o_score       = score_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_class       = class_q;

endmodule

// File: tb/tb_dense_feeder.sv
module tb_dense_feeder;

  localparam int NF     = 4;
  localparam int NC     = 3;
  localparam int FEAT_W = 24;
  localparam int WGT_W  = 24;
  localparam int ACC_W  = 56;
  localparam int FA_W   = 2;
  localparam int WA_W   = 4;
  localparam int CI_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    i_start = 1'b0;
  logic [FA_W-1:0]         o_feat_addr;
  logic [FEAT_W-1:0]       i_feat_data = '0;
  logic [WA_W-1:0]         o_wgt_addr;
  logic signed [WGT_W-1:0] i_wgt_data = '0;
  logic                    o_mac_clr, o_mac_valid, o_mac_last;
  logic [FEAT_W-1:0]       o_ni_rd;
  logic signed [WGT_W-1:0] o_weight;
  logic                    i_mac_done = 1'b0;
  logic signed [ACC_W-1:0] i_mac_dout = '0;
  logic                    o_score_valid;
  logic [CI_W-1:0]         o_score_idx;
  logic signed [ACC_W-1:0] o_score;
  logic                    o_busy, o_done;
  logic [CI_W-1:0]         o_class;

  dense_feeder #(
    .N_FEAT(NF), .N_CLASS(NC), .FEAT_W(FEAT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .o_feat_addr(o_feat_addr), .i_feat_data(i_feat_data),
    .o_wgt_addr(o_wgt_addr), .i_wgt_data(i_wgt_data),
    .o_mac_clr(o_mac_clr), .o_mac_valid(o_mac_valid), .o_mac_last(o_mac_last),
    .o_ni_rd(o_ni_rd), .o_weight(o_weight),
    .i_mac_done(i_mac_done), .i_mac_dout(i_mac_dout),
    .o_score_valid(o_score_valid), .o_score_idx(o_score_idx), .o_score(o_score),
    .o_busy(o_busy), .o_done(o_done), .o_class(o_class)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Memories and reference model
  logic [FEAT_W-1:0]       fmem[NF];
  logic signed [WGT_W-1:0] wmem[16];
  longint                  exp_score[NC];
  int                      exp_best;

  always @(posedge clk) begin
    i_feat_data <= fmem[o_feat_addr];
    i_wgt_data  <= wmem[o_wgt_addr];
  end

  task automatic build_model();
    for (int c = 0; c < NC; c++) begin
      exp_score[c] = 0;
      for (int f = 0; f < NF; f++)
        exp_score[c] += longint'(fmem[f]) * longint'(wmem[c*NF+f]);
    end
    exp_best = 0;
    for (int c = 1; c < NC; c++)
      if (exp_score[c] > exp_score[exp_best]) exp_best = c;
  endtask

  // Behavioural MAC: accumulates beats, answers done_delay cycles after
  // the nominal "one cycle after last".
  int     done_delay = 0;
  logic   spur_req = 1'b0;
  longint acc = 0;
  longint acc_nx;
  logic   pend = 1'b0;
  int     cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      acc        <= 0;
      i_mac_done <= 1'b0;
    end else begin
      i_mac_done <= spur_req;
      if (spur_req) i_mac_dout <= 56'h5A5A5A;
      if (pend) begin
        if (cnt == 0) begin
          pend       <= 1'b0;
          i_mac_done <= 1'b1;
          i_mac_dout <= acc[ACC_W-1:0];
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (o_mac_clr) begin
        acc <= 0;
      end else if (o_mac_valid) begin
        acc_nx = acc + longint'(o_ni_rd) * longint'(o_weight);
        acc <= acc_nx;
        if (o_mac_last) begin
          if (done_delay == 0) begin
            i_mac_done <= 1'b1;
            i_mac_dout <= acc_nx[ACC_W-1:0];
          end else begin
            pend <= 1'b1;
            cnt  <= done_delay - 1;
          end
        end
      end
    end
  end

  // Monitor
  int              mon_cls;
  int              clr_cnt;
  int              busy_cyc;
  int              beats[8];
  int              sidx_q[$];
  longint          sval_q[$];
  int              cls_q[$];
  logic [FA_W-1:0] fa_d1 = '0, fa_d2 = '0;
  logic [WA_W-1:0] wa_d1 = '0, wa_d2 = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_busy) busy_cyc++;
      if (o_mac_clr) begin
        mon_cls++;
        clr_cnt++;
      end
      if (!o_mac_valid && o_mac_last) check("mac_last_stray", o_mac_last, 0);
      if (o_mac_valid) begin
        if (mon_cls < 0 || mon_cls > 7) begin
          check("beat_class_index", mon_cls, 0);
        end else begin
          automatic int k = beats[mon_cls];
          automatic int c = mon_cls % NC;
          check("feat_addr", fa_d2, k);
          check("wgt_addr", wa_d2, c*NF + k);
          check("ni_rd", o_ni_rd, fmem[k % NF]);
          check("weight", o_weight, wmem[c*NF + (k % NF)]);
          check("mac_last", o_mac_last, k == NF-1);
          beats[mon_cls]++;
        end
      end
      if (o_score_valid) begin
        sidx_q.push_back(int'(o_score_idx));
        sval_q.push_back(longint'(o_score));
      end
      if (o_done) cls_q.push_back(int'(o_class));
    end
    fa_d2 = fa_d1; fa_d1 = o_feat_addr;
    wa_d2 = wa_d1; wa_d1 = o_wgt_addr;
  end

  task automatic clear_mon();
    mon_cls = -1; clr_cnt = 0; busy_cyc = 0;
    for (int i = 0; i < 8; i++) beats[i] = 0;
    sidx_q.delete(); sval_q.delete(); cls_q.delete();
  endtask

  task automatic start_run();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (cls_q.size() < n && t < budget) begin
      @(negedge clk); t++;
    end
    check("done_within_budget", cls_q.size() >= n, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_run(input int nr, input int d);
    check("n_scores", sidx_q.size(), NC*nr);
    for (int i = 0; i < sidx_q.size() && i < NC*nr; i++) begin
      check("score_idx", sidx_q[i], i % NC);
      check("score", sval_q[i], exp_score[i % NC]);
    end
    check("n_done", cls_q.size(), nr);
    for (int i = 0; i < cls_q.size(); i++) check("class", cls_q[i], exp_best);
    check("n_clr", clr_cnt, NC*nr);
    for (int i = 0; i < NC*nr; i++) check("beats_per_class", beats[i], NF);
    if (nr == 1) check("busy_cycles", busy_cyc, NC*(1 + NF + 2 + (1 + d) + 1) + 1);
    check("busy_after_done", o_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_feat_addr"}, o_feat_addr, 0);
    check({tag, "_wgt_addr"}, o_wgt_addr, 0);
    check({tag, "_mac_clr"}, o_mac_clr, 0);
    check({tag, "_mac_valid"}, o_mac_valid, 0);
    check({tag, "_mac_last"}, o_mac_last, 0);
    check({tag, "_ni_rd"}, o_ni_rd, 0);
    check({tag, "_weight"}, o_weight, 0);
    check({tag, "_score_valid"}, o_score_valid, 0);
    check({tag, "_score_idx"}, o_score_idx, 0);
    check({tag, "_score"}, o_score, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_class"}, o_class, 0);
  endtask

  task automatic load_flat(input int fv, input int w0, input int w1, input int w2);
    for (int f = 0; f < NF; f++) begin
      fmem[f] = FEAT_W'(fv);
      wmem[f] = WGT_W'(w0);
      wmem[NF+f] = WGT_W'(w1);
      wmem[2*NF+f] = WGT_W'(w2);
    end
    for (int i = NC*NF; i < 16; i++) wmem[i] = '0;
  endtask

  task automatic load_random();
    for (int f = 0; f < NF; f++) fmem[f] = FEAT_W'($urandom);
    for (int i = 0; i < 16; i++) wmem[i] = WGT_W'($urandom);
  endtask

  initial begin
    clear_mon();
    load_flat(0, 0, 0, 0);
    build_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic run: scores 4, 8, -4 -> class 1
    load_flat(1, 1, 2, -1);
    build_model();
    clear_mon();
    done_delay = 0;
    start_run();
    wait_done(1, 200);
    check_run(1, 0);

    // Ties keep the lower index
    load_flat(1, 1, 1, 1);
    fmem[3] = 24'd2;
    build_model();
    clear_mon();
    start_run();
    wait_done(1, 200);
    check_run(1, 0);

    // All negative: -9, -3, -3 -> class 1
    load_flat(1, 0, 0, 0);
    wmem[0] = -24'sd3; wmem[1] = -24'sd3; wmem[2] = -24'sd2; wmem[3] = -24'sd1;
    wmem[4] = -24'sd1; wmem[5] = -24'sd1; wmem[6] = -24'sd1; wmem[7] = 24'sd0;
    wmem[8] = 24'sd0;  wmem[9] = -24'sd1; wmem[10] = -24'sd1; wmem[11] = -24'sd1;
    build_model();
    clear_mon();
    start_run();
    wait_done(1, 200);
    check_run(1, 0);

    // Randomised runs with small MAC latencies
    for (int r = 0; r < 4; r++) begin
      load_random();
      build_model();
      done_delay = $urandom_range(0, 3);
      clear_mon();
      start_run();
      wait_done(1, 300);
      check_run(1, done_delay);
    end

    // MAC back-pressure plus a spurious done during streaming
    load_random();
    build_model();
    done_delay = 20;
    clear_mon();
    start_run();
    repeat (2) @(negedge clk);
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    wait_done(1, 400);
    check_run(1, 20);
    done_delay = 0;

    // i_start pulsed while busy is ignored
    load_random();
    build_model();
    clear_mon();
    start_run();
    repeat (10) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(1, 200);
    repeat (20) @(negedge clk);
    check_run(1, 0);

    // i_start held across DONE starts a fresh run from class 0
    load_random();
    build_model();
    clear_mon();
    @(negedge clk);
    i_start = 1'b1;
    wait_done(1, 200);
    i_start = 1'b0;
    wait_done(2, 200);
    repeat (5) @(negedge clk);
    check_run(2, 0);

    // Reset during class 1 streaming abandons the run
    load_random();
    build_model();
    clear_mon();
    start_run();
    begin
      int t = 0;
      while (!(mon_cls == 1 && beats[1] >= 2) && t < 100) begin
        @(negedge clk); t++;
      end
      check("reach_class1_stream", t < 100, 1);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", cls_q.size(), 0);
    check("idle_after_reset", o_busy, 0);

    // Fresh run after the abandoned one
    load_random();
    build_model();
    clear_mon();
    start_run();
    wait_done(1, 200);
    check_run(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
